// File: rtl/car_spawn_gen_if.sv
// rtl/car_spawn_gen_if.sv - control and observation bundle between the spawn driver and car_spawn_gen
interface car_spawn_gen_if #(
   parameter int LFSR_W = 16,
   parameter int CNT_W  = 8
) ();
   logic              enable;
   logic [2:0]        density;
   logic              force_car;
   logic              add_car_rand;
   logic [CNT_W-1:0]  car_count;
   logic [LFSR_W-1:0] lfsr_state;

   modport master (
      output enable, density, force_car,
      input  add_car_rand, car_count, lfsr_state
   );

   modport slave (
      input  enable, density, force_car,
      output add_car_rand, car_count, lfsr_state
   );
endinterface

// File: rtl/car_spawn_gen.sv
// rtl/car_spawn_gen.sv - LFSR-driven car spawner emitting spaced one-cycle add pulses
module car_spawn_gen #(
   parameter int                LFSR_W  = 16,
   parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(16'hACE1),
   parameter int                HOLDOFF = 4,
   parameter int                CNT_W   = 8
) (
   input  logic            traffic_clk,
   input  logic            reset,
   car_spawn_gen_if.slave  bus
);

   localparam logic [LFSR_W-1:0] LFSR_MASK = LFSR_W'(16'hB400);
   localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? LFSR_W'(1) : SEED;
   localparam int                HC_W      = $clog2(HOLDOFF + 1);
   localparam logic [HC_W-1:0]   HOLD_LOAD = HC_W'(HOLDOFF - 2);

   localparam logic [1:0] ARMED = 2'd0;
   localparam logic [1:0] FIRE  = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic              force_pend_q, force_pend_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0]  car_count_q, car_count_d;
   logic              hit;

   always_comb begin
      lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : '0);
      hit          = bus.enable && (force_pend_q || bus.force_car || (lfsr_q[2:0] < bus.density));
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      force_pend_d = force_pend_q;
      car_count_d  = car_count_q;

      // A request that cannot be served this cycle is remembered (one deep).
      if (bus.force_car && ((state_q != ARMED) || !bus.enable)) begin
         force_pend_d = 1'b1;
      end

      case (state_q)
         ARMED: begin
            if (hit) begin
               state_d      = FIRE;
               force_pend_d = 1'b0;
               if (car_count_q != '1) begin
                  car_count_d = car_count_q + CNT_W'(1);
               end
            end
         end
         FIRE: begin
            if (HOLDOFF == 2) begin
               state_d = ARMED;
            end else begin
               state_d    = HOLD;
               hold_cnt_d = HOLD_LOAD;
            end
         end
         HOLD: begin
            hold_cnt_d = hold_cnt_q - HC_W'(1);
            if (hold_cnt_q == HC_W'(1)) begin
               state_d = ARMED;
            end
         end
         default: begin
            state_d = ARMED;
         end
      endcase
   end

   always_ff @(posedge traffic_clk) begin
      if (reset) begin
         state_q      <= ARMED;
         hold_cnt_q   <= '0;
         force_pend_q <= 1'b0;
         lfsr_q       <= SEED_EFF;
         car_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         force_pend_q <= force_pend_d;
         lfsr_q       <= lfsr_d;
         car_count_q  <= car_count_d;
      end
   end

   assign bus.add_car_rand = (state_q == FIRE);
   assign bus.car_count    = car_count_q;
   assign bus.lfsr_state   = lfsr_q;

endmodule

// File: tb/tb_car_spawn_gen.sv
// tb/tb_car_spawn_gen.sv - directed checks of car_spawn_gen pulse timing, forcing and saturation
module tb_car_spawn_gen;

   logic traffic_clk;
   logic reset;

   car_spawn_gen_if #(.LFSR_W(16), .CNT_W(8)) bus ();
   car_spawn_gen_if #(.LFSR_W(16), .CNT_W(3)) bus_s ();

   car_spawn_gen #(.CNT_W(8)) dut (
      .traffic_clk (traffic_clk),
      .reset       (reset),
      .bus         (bus.slave)
   );

   car_spawn_gen #(.CNT_W(3)) dut_s (
      .traffic_clk (traffic_clk),
      .reset       (reset),
      .bus         (bus_s.slave)
   );

   initial traffic_clk = 1'b0;
   always #5 traffic_clk = ~traffic_clk;

   int n_checks = 0;
   int n_pass   = 0;

   int cyc, pulses, wide, bad_eq, bad_ge, last_rise, lfsr_err;
   bit have_last, prev_add;
   int pulses_s, sat_err;
   logic [15:0] exp_lfsr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic clear_stats();
      pulses = 0; wide = 0; bad_eq = 0; bad_ge = 0;
      have_last = 0; prev_add = 0; last_rise = 0;
      pulses_s = 0; sat_err = 0;
   endtask

   // One clock edge; observe outputs 1 time unit later and update the bench-side models.
   task automatic tick();
      bit rst_now;
      @(posedge traffic_clk);
      rst_now = reset;
      #1;
      cyc++;
      exp_lfsr = rst_now ? 16'hACE1 : lfsr_step(exp_lfsr);
      if (bus.lfsr_state !== exp_lfsr) lfsr_err++;
      if (bus.add_car_rand) begin
         if (prev_add) wide++;
         else begin
            if (have_last && (cyc - last_rise) != 4) bad_eq++;
            if (have_last && (cyc - last_rise) < 4) bad_ge++;
            last_rise = cyc;
            have_last = 1;
         end
         pulses++;
      end
      prev_add = bus.add_car_rand;
      if (bus_s.add_car_rand) begin
         pulses_s++;
         if (32'(bus_s.car_count) != ((pulses_s > 7) ? 7 : pulses_s)) sat_err++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      run(n);
      reset = 1'b0;
   endtask

   initial begin
      cyc = 0; lfsr_err = 0; exp_lfsr = 16'hACE1;
      clear_stats();
      reset = 1'b1;
      bus.enable = 1'b1; bus.density = 3'd7; bus.force_car = 1'b0;
      bus_s.enable = 1'b1; bus_s.density = 3'd7; bus_s.force_car = 1'b1;

      // Reset held three cycles with spawning conditions active
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_add", 32'(bus.add_car_rand), 32'd0);
         check("rst_cnt", 32'(bus.car_count), 32'd0);
         check("rst_lfsr", 32'(bus.lfsr_state), 32'hACE1);
      end
      reset = 1'b0;
      tick();
      check("first_lfsr", 32'(bus.lfsr_state), 32'hE270);
      check("first_pulse", 32'(bus.add_car_rand), 32'd1);
      check("first_cnt", 32'(bus.car_count), 32'd1);

      // Saturated rate: force held high for 40 cycles
      bus.force_car = 1'b1;
      do_reset(2);
      clear_stats();
      run(40);
      check("sat_pulses", 32'(pulses), 32'd10);
      check("sat_wide", 32'(wide), 32'd0);
      check("sat_spacing", 32'(bad_eq), 32'd0);
      check("sat_cnt", 32'(bus.car_count), 32'd10);

      // Zero density, then disabled at full density
      bus.force_car = 1'b0;
      bus.density = 3'd0;
      do_reset(2);
      clear_stats();
      run(200);
      check("d0_pulses", 32'(pulses), 32'd0);
      check("d0_cnt", 32'(bus.car_count), 32'd0);
      bus.enable = 1'b0;
      bus.density = 3'd7;
      clear_stats();
      run(200);
      check("dis_pulses", 32'(pulses), 32'd0);
      check("dis_cnt", 32'(bus.car_count), 32'd0);

      // Force pulse during HOLD is deferred to the first ARMED cycle
      bus.enable = 1'b1;
      bus.density = 3'd0;
      bus.force_car = 1'b1;
      do_reset(2);
      clear_stats();
      tick();
      check("pend_fire", 32'(bus.add_car_rand), 32'd1);
      bus.force_car = 1'b0;
      tick();
      check("pend_hold1", 32'(bus.add_car_rand), 32'd0);
      bus.force_car = 1'b1;
      tick();
      bus.force_car = 1'b0;
      check("pend_hold2", 32'(bus.add_car_rand), 32'd0);
      tick();
      check("pend_armed", 32'(bus.add_car_rand), 32'd0);
      tick();
      check("pend_pulse", 32'(bus.add_car_rand), 32'd1);
      run(20);
      check("pend_total", 32'(pulses), 32'd2);
      check("pend_cnt", 32'(bus.car_count), 32'd2);

      // Force while disabled fires once enable returns
      bus.enable = 1'b0;
      bus.density = 3'd0;
      bus.force_car = 1'b0;
      do_reset(2);
      clear_stats();
      run(2);
      bus.force_car = 1'b1;
      tick();
      bus.force_car = 1'b0;
      run(3);
      check("dis_force_quiet", 32'(pulses), 32'd0);
      bus.enable = 1'b1;
      tick();
      check("dis_force_pulse", 32'(bus.add_car_rand), 32'd1);
      run(10);
      check("dis_force_total", 32'(pulses), 32'd1);
      check("dis_force_cnt", 32'(bus.car_count), 32'd1);

      // 3-bit counter saturates at 7 while pulses continue
      do_reset(2);
      clear_stats();
      run(48);
      check("cnt3_pulses", 32'(pulses_s), 32'd12);
      check("cnt3_cnt", 32'(bus_s.car_count), 32'd7);
      check("cnt3_track", 32'(sat_err), 32'd0);

      // Reset landing on a FIRE cycle
      bus.enable = 1'b1;
      bus.density = 3'd7;
      bus.force_car = 1'b1;
      do_reset(2);
      clear_stats();
      tick();
      check("midrst_fire", 32'(bus.add_car_rand), 32'd1);
      reset = 1'b1;
      tick();
      check("midrst_add", 32'(bus.add_car_rand), 32'd0);
      check("midrst_lfsr", 32'(bus.lfsr_state), 32'hACE1);
      check("midrst_cnt", 32'(bus.car_count), 32'd0);
      reset = 1'b0;
      tick();
      check("midrst_restart", 32'(bus.lfsr_state), 32'hE270);

      // Density 4 free run: every pulse counted, spacing and width held
      bus.force_car = 1'b0;
      bus.density = 3'd4;
      do_reset(2);
      clear_stats();
      run(500);
      check("d4_some", 32'(pulses > 0), 32'd1);
      check("d4_cnt", 32'(bus.car_count), 32'(pulses));
      check("d4_spacing", 32'(bad_ge), 32'd0);
      check("d4_wide", 32'(wide), 32'd0);

      check("lfsr_seq", 32'(lfsr_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
